// File: rtl/window_minmax.sv
// Windowed running max/min tracker with index capture, fed by the 8-bit
// magnitude comparator; one result per WINDOW accepted samples.

module comparator8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       p,
  output logic       q
);
  assign p = (a > b);
  assign q = (a < b);
endmodule

module window_minmax #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned IDXW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_max,
  output logic [7:0]      out_min,
  output logic [IDXW-1:0] out_max_idx,
  output logic [IDXW-1:0] out_min_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WINDOW - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] count_q, count_d;
  logic [7:0]      max_q, max_d, min_q, min_d;
  logic [IDXW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic gt_max, lt_min;
  logic cmp_max_lt_unused, cmp_min_gt_unused;
  logic accept;

  // in_data > stored max, and in_data < stored min
  comparator8 u_cmp_max (.a(in_data), .b(max_q), .p(gt_max),            .q(cmp_max_lt_unused));
  comparator8 u_cmp_min (.a(in_data), .b(min_q), .p(cmp_min_gt_unused), .q(lt_min));

  assign accept = in_valid && (state_q == ACCUM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      max_q       <= max_d;
      min_q       <= min_d;
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    max_d       = max_q;
    min_d       = min_q;
    max_idx_d   = max_idx_q;
    min_idx_d   = min_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (count_q == '0) begin
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
          end else begin
            // strict compares so ties keep the earlier index
            if (gt_max) begin
              max_d     = in_data;
              max_idx_d = count_q;
            end
            if (lt_min) begin
              min_d     = in_data;
              min_idx_d = count_q;
            end
          end
          if (count_q == LAST_IDX) begin
            state_d     = HOLD;
            count_d     = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            count_d = count_q + IDXW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    // abort wins over any same-cycle accept or output handshake
    if (clear) begin
      state_d     = ACCUM;
      count_d     = '0;
      max_d       = max_q;
      min_d       = min_q;
      max_idx_d   = max_idx_q;
      min_idx_d   = min_idx_q;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;

endmodule

// File: tb/tb_window_minmax.sv
// Directed self-checking bench for window_minmax (WINDOW=8).

module tb_window_minmax;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic [2:0] out_max_idx;
  logic [2:0] out_min_idx;

  int checks = 0;
  int errors = 0;

  window_minmax #(.WINDOW(8), .IDXW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx)
  );

  always #5 clk = ~clk;

  // {valid, max, max_idx, min, min_idx}
  logic [22:0] res;
  assign res = {out_valid, out_max, out_max_idx, out_min, out_min_idx};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
      errors++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_window(input logic [63:0] s);
    for (int i = 0; i < 8; i++) push(s[63 - 8*i -: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #12;
    checks++;
    if ({in_ready, res} !== {1'b1, 23'h0}) begin
      $display("FAIL reset_state: ready=%b res=%h required ready=1 res=000000", in_ready, res);
      errors++;
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push_window(64'h05_09_03_09_01_07_01_02);
    checks++;
    if (res !== {1'b1, 8'd9, 3'd1, 8'd1, 3'd4}) begin
      $display("FAIL basic_result: got %h required %h", res, {1'b1, 8'd9, 3'd1, 8'd1, 3'd4});
      errors++;
    end
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL basic_hold_ready: in_ready=%b required 0", in_ready);
      errors++;
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL basic_after_hs: valid,ready=%b required 01", {out_valid, in_ready});
      errors++;
    end
  endtask

  task automatic test_back_pressure();
    logic [22:0] exp;
    exp = {1'b1, 8'd40, 3'd3, 8'd5, 3'd7};
    out_ready = 1'b0;
    push_window(64'h14_1E_0A_28_19_0F_23_05);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready, res} !== {1'b0, exp}) begin
        $display("FAIL bp_hold_%0d: ready=%b res=%h required ready=0 res=%h", c, in_ready, res, exp);
        errors++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL bp_release: valid,ready=%b required 01", {out_valid, in_ready});
      errors++;
    end
    // all-equal window, also proves the held 99 was never consumed
    push_window(64'h03_03_03_03_03_03_03_03);
    checks++;
    if (res !== {1'b1, 8'd3, 3'd0, 8'd3, 3'd0}) begin
      $display("FAIL bp_next_equal: got %h required %h", res, {1'b1, 8'd3, 3'd0, 8'd3, 3'd0});
      errors++;
    end
    step();
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    push_window(64'hFF_00_80_FF_00_7F_01_FE);
    checks++;
    if (res !== {1'b1, 8'hFF, 3'd0, 8'h00, 3'd1}) begin
      $display("FAIL extremes: got %h required %h", res, {1'b1, 8'hFF, 3'd0, 8'h00, 3'd1});
      errors++;
    end
    step();
  endtask

  task automatic test_gappy();
    logic [29:0] pat;
    int k;
    logic took;
    pat = 30'b110100101101100101101001011011;
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_valid = pat[c] && (k < 8);
      in_data  = (k < 8) ? 8'(10 + k) : 8'hEE;
      if (!in_valid) in_data = 8'hEE;
      took = in_valid && in_ready;
      step();
      in_valid = 1'b0;
      if (took) begin
        k++;
        checks++;
        if (out_valid !== (k == 8)) begin
          $display("FAIL gappy_valid_k%0d: out_valid=%b required %b", k, out_valid, (k == 8));
          errors++;
        end
        if (k == 8) begin
          checks++;
          if (res !== {1'b1, 8'd17, 3'd7, 8'd10, 3'd0}) begin
            $display("FAIL gappy_result: got %h required %h", res, {1'b1, 8'd17, 3'd7, 8'd10, 3'd0});
            errors++;
          end
        end
      end
    end
    checks++;
    if (k != 8) begin
      $display("FAIL gappy_accepts: got %0d required 8", k);
      errors++;
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    push(8'd200); push(8'd201); push(8'd202); push(8'd203);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd250;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL clear_mid: valid,ready=%b required 01", {out_valid, in_ready});
      errors++;
    end
    push_window(64'h32_3C_28_3C_46_28_2D_37);
    checks++;
    if (res !== {1'b1, 8'd70, 3'd4, 8'd40, 3'd2}) begin
      $display("FAIL clear_window: got %h required %h", res, {1'b1, 8'd70, 3'd4, 8'd40, 3'd2});
      errors++;
    end
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        $display("FAIL clear_hold_%0d: valid,ready=%b required 01", c, {out_valid, in_ready});
        errors++;
      end
      step();
    end
    push_window(64'h64_5A_6E_50_78_46_82_3C);
    checks++;
    if (res !== {1'b1, 8'd130, 3'd6, 8'd60, 3'd7}) begin
      $display("FAIL clear_fresh: got %h required %h", res, {1'b1, 8'd130, 3'd6, 8'd60, 3'd7});
      errors++;
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push_window(64'h11_22_33_44_55_66_77_88);
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL ares_pre: out_valid=%b required 1", out_valid);
      errors++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_max} !== {1'b0, 1'b1, 8'h00}) begin
      $display("FAIL ares_during: valid,ready,max=%b,%b,%h required 0,1,00", out_valid, in_ready, out_max);
      errors++;
    end
    #3 reset = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL ares_after: valid,ready=%b required 01", {out_valid, in_ready});
      errors++;
    end
    push_window(64'h07_06_05_04_03_02_01_08);
    checks++;
    if (res !== {1'b1, 8'd8, 3'd7, 8'd1, 3'd6}) begin
      $display("FAIL ares_restart: got %h required %h", res, {1'b1, 8'd8, 3'd7, 8'd1, 3'd6});
      errors++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_extremes();
    test_gappy();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_minmax.md
Name: window_minmax

Overview:
- Streaming stage downstream of the 8-bit unsigned magnitude comparator (P = A>B, Q = A<B).
- Accepts 8-bit samples over a valid/ready handshake and tracks running max and min, plus the window index of each, across a window of WINDOW samples.
- Presents the window result on a valid/ready output port, then starts the next window.
- Comparisons use the team's comparator8 instance(s); no other magnitude logic.

Parameters:
- WINDOW, 8, samples per window; legal 2..256.
- IDXW, 3, index width; must equal clog2(WINDOW).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort of current window and any pending result
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  8  unsigned sample
- out_valid  output  1  window result available
- out_ready  input  1  consumer takes the result
- out_max  output  8  largest sample in window
- out_min  output  8  smallest sample in window
- out_max_idx  output  IDXW  position (0-based) of out_max within window
- out_min_idx  output  IDXW  position of out_min within window

Behaviour:
- Reset (reset=0, asynchronous): state ACCUM, count=0, out_valid=0, in_ready=1, out_max=0, out_min=0, out_max_idx=0, out_min_idx=0. All registers hold reset values while reset=0.
- Accept event: in_valid & in_ready at a rising edge. No sample is consumed otherwise.
- FSM state ACCUM:
  - in_ready=1, out_valid=0.
  - On accept with count==0: max=min=in_data; both idx=0.
  - On accept with count>0: compare in_data against the stored max and the stored min.
    - If in_data > max (strict): max=in_data, max_idx=count.
    - If in_data < min (strict): min=in_data, min_idx=count.
    - Ties keep the earlier index.
  - count increments on each accept.
  - On the accept where count==WINDOW-1: go to HOLD and clear count to 0.
- FSM state HOLD:
  - in_ready=0, out_valid=1.
  - out_* registered and stable until handshake; must not change while out_valid & !out_ready.
  - out_valid & out_ready: go to ACCUM next cycle. out_* keep last values; they are don't-care while out_valid=0.
- Latency: out_valid rises the cycle after the WINDOW-th accept. No sample is accepted in the handshake cycle itself.
- Throughput: one window per WINDOW+1 cycles minimum.
- clear=1:
  - Next state ACCUM, count=0, out_valid=0.
  - Overrides any simultaneous accept or output handshake; that sample is dropped and the pending result is discarded.
  - Stored max/min are not zeroed, but are overwritten by the next window's first sample.
- Reset mid-window or during HOLD: partial window and result are lost; state as in the reset bullet.
- Equal samples across the whole window: max=min=value, both idx=0.
- Values 8'h00 and 8'hFF must compare correctly (unsigned); no signed interpretation.
- in_data is sampled only on accept. in_valid may drop without completing a transfer.

Test Plan:
- Reset then stream 8 samples 5,9,3,9,1,7,1,2 with in_valid=1 and out_ready=1 -> one cycle after 8th accept: out_valid=1, out_max=9, out_max_idx=1, out_min=1, out_min_idx=4; in_ready=1 the following cycle.
- Back-pressure: complete a window with out_ready=0 for 5 cycles -> out_valid held at 1, out_* constant, in_ready=0, extra in_valid samples not consumed; out_ready=1 -> handshake, next window starts clean.
- Extremes: window 0xFF,0x00,0x80,0xFF,0x00,0x7F,0x01,0xFE -> out_max=0xFF idx 0, out_min=0x00 idx 1.
- Gappy input: in_valid toggling pseudo-randomly over 30 cycles with 8 accepts of 10..17 ascending -> max=17 idx 7, min=10 idx 0; bubbles do not advance count.
- clear asserted after 4 accepts and again while out_valid=1 in the same cycle as out_ready=1 -> no result emitted; next 8 accepts produce a fresh correct window.
- reset pulsed low asynchronously, mid-cycle, during HOLD -> out_valid drops immediately, in_ready=1 after release, count restarts at 0.
